// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one single-port memory between an instruction-fetch
//               requester and a data requester. One transfer is in flight at a
//               time: IDLE grants, ACCESS drives the memory for LAT cycles,
//               RESP pulses the owner's ack for one cycle. Data normally wins;
//               fetch is forced through after STARVE consecutive data grants
//               made while fetch was waiting.
// Ports       : clk, rst                    - clock, synchronous active-high reset
//               if_req/if_addr              - fetch request (level) and word address
//               if_rdata/if_ack             - fetched word, completion pulse
//               d_req/d_we/d_addr/d_wdata   - data request (level), write flag, address, value
//               d_rdata/d_ack               - read value, completion pulse
//               mem_en/mem_we/mem_addr/
//               mem_wdata/mem_rdata         - memory access port
//               stall                       - any request still waiting for its ack
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int LAT    = 2,
    parameter int STARVE = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [7:0]  if_addr,
    output logic [15:0] if_rdata,
    output logic        if_ack,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [7:0]  d_addr,
    input  logic [15:0] d_wdata,
    output logic [15:0] d_rdata,
    output logic        d_ack,
    output logic        mem_en,
    output logic        mem_we,
    output logic [7:0]  mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    output logic        stall
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    localparam logic [3:0] C_CNT_INIT = 4'(LAT - 1);
    localparam logic [3:0] C_STARVE   = 4'(STARVE);
    localparam logic [3:0] C_SAT      = 4'hF;

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_cnt;
    logic [3:0]  r_starve;
    logic        r_own_d;     // 1: data port owns the transfer, 0: fetch port
    logic        r_we;
    logic [7:0]  r_addr;
    logic [15:0] r_wdata;
    logic [15:0] r_if_rdata;
    logic [15:0] r_d_rdata;

    logic        w_any_req;
    logic        w_grant;
    logic        w_grant_if;

    always_comb begin
        w_any_req  = if_req | d_req;
        w_grant    = (r_state == S_IDLE) & w_any_req;
        // Fetch only beats a simultaneous data request once starvation limit is hit.
        w_grant_if = if_req & (~d_req | (r_starve == C_STARVE));
    end

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_any_req) w_next = S_ACCESS;
            S_ACCESS: if (r_cnt == 4'd0) w_next = S_RESP;
            S_RESP:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // ----------------------------------------------------------- datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= 4'd0;
            r_starve   <= 4'd0;
            r_own_d    <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= 8'd0;
            r_wdata    <= 16'd0;
            r_if_rdata <= 16'd0;
            r_d_rdata  <= 16'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // Starvation only accumulates while fetch is actually waiting.
                    if (!if_req || (w_grant && w_grant_if)) begin
                        r_starve <= 4'd0;
                    end else if (w_grant && (r_starve != C_SAT)) begin
                        r_starve <= r_starve + 4'd1;
                    end
                    if (w_grant) begin
                        r_own_d <= ~w_grant_if;
                        r_we    <= d_we;
                        r_addr  <= w_grant_if ? if_addr : d_addr;
                        r_wdata <= d_wdata;
                        r_cnt   <= C_CNT_INIT;
                    end
                end
                S_ACCESS: begin
                    if (r_cnt == 4'd0) begin
                        if (!r_own_d) begin
                            r_if_rdata <= mem_rdata;
                        end else if (!r_we) begin
                            r_d_rdata <= mem_rdata;
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------ outputs
    // Strobes and acks are also masked by rst so nothing leaks out in the
    // cycle where reset is first asserted.
    assign mem_en    = (r_state == S_ACCESS) & ~rst;
    assign mem_we    = (r_state == S_ACCESS) & r_own_d & r_we & ~rst;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign if_ack    = (r_state == S_RESP) & ~r_own_d & ~rst;
    assign d_ack     = (r_state == S_RESP) & r_own_d & ~rst;
    assign if_rdata  = r_if_rdata;
    assign d_rdata   = r_d_rdata;
    assign stall     = (if_req & ~if_ack) | (d_req & ~d_ack);

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench for mem_port_arbiter: directed scenarios
//               plus randomized traffic checked against a cycle-timeline
//               reference model of the arbitration rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int LAT    = 2;
    localparam int STARVE = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [7:0]  if_addr;
    logic [15:0] if_rdata;
    logic        if_ack;
    logic        d_req;
    logic        d_we;
    logic [7:0]  d_addr;
    logic [15:0] d_wdata;
    logic [15:0] d_rdata;
    logic        d_ack;
    logic        mem_en;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        stall;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [15:0] mem     [256];
    logic [15:0] ref_mem [256];

    mem_port_arbiter #(.LAT(LAT), .STARVE(STARVE)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .stall(stall)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: combinational read, write on the clock edge.
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) begin
        if (mem_en && mem_we) mem[mem_addr] = mem_wdata;
    end

    task automatic test_reset();
        rst = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        if_addr = 8'd0; d_addr = 8'd0; d_wdata = 16'd0;
        for (int i = 0; i < 256; i++) mem[i] = 16'(i);
        @(posedge clk); #1;
        if_req = 1'b1; d_req = 1'b1; d_we = 1'b1; d_addr = 8'd9; d_wdata = 16'hBEEF;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_checks++; if (mem_en !== 1'b0 || mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_strobes c%0d got en=%b we=%b exp 0 0", c, mem_en, mem_we); end
            n_checks++; if (if_ack !== 1'b0 || d_ack !== 1'b0) begin n_fail++; $display("FAIL rst_acks c%0d got if=%b d=%b exp 0 0", c, if_ack, d_ack); end
            @(posedge clk); #1;
        end
        @(negedge clk);
        n_checks++; if (if_rdata !== 16'd0 || d_rdata !== 16'd0) begin n_fail++; $display("FAIL rst_rdata got if=%h d=%h exp 0 0", if_rdata, d_rdata); end
        n_checks++; if (mem_addr !== 8'd0 || mem_wdata !== 16'd0) begin n_fail++; $display("FAIL rst_memreg got a=%h w=%h exp 0 0", mem_addr, mem_wdata); end
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL rst_stall got %b exp 1", stall); end
        @(posedge clk); #1;
        rst = 1'b0; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        @(negedge clk);
        n_checks++; if (mem_en !== 1'b0 || if_ack !== 1'b0 || d_ack !== 1'b0 || stall !== 1'b0) begin n_fail++; $display("FAIL rst_release got en=%b ia=%b da=%b st=%b exp 0", mem_en, if_ack, d_ack, stall); end
    endtask

    task automatic test_fetch();
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 8'd5;
        @(negedge clk);
        n_checks++; if (mem_en !== 1'b0 || stall !== 1'b1) begin n_fail++; $display("FAIL fetch_c0 got en=%b stall=%b exp 0 1", mem_en, stall); end
        for (int c = 1; c <= LAT; c++) begin
            @(negedge clk);
            n_checks++; if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 8'd5) begin n_fail++; $display("FAIL fetch_access c%0d got en=%b we=%b a=%0d exp 1 0 5", c, mem_en, mem_we, mem_addr); end
        end
        @(negedge clk);
        n_checks++; if (if_ack !== 1'b1 || if_rdata !== 16'd5) begin n_fail++; $display("FAIL fetch_ack got ack=%b data=%0d exp 1 5", if_ack, if_rdata); end
        n_checks++; if (stall !== 1'b0 || mem_en !== 1'b0 || d_ack !== 1'b0) begin n_fail++; $display("FAIL fetch_resp got st=%b en=%b da=%b exp 0 0 0", stall, mem_en, d_ack); end
        @(posedge clk); #1;
        if_req = 1'b0;
    endtask

    task automatic test_write_read();
        // Write 30 to address 250.
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b1; d_addr = 8'd250; d_wdata = 16'd30;
        @(negedge clk);
        for (int c = 1; c <= LAT; c++) begin
            @(negedge clk);
            n_checks++; if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 8'd250 || mem_wdata !== 16'd30) begin n_fail++; $display("FAIL write_access c%0d got en=%b we=%b a=%0d w=%0d exp 1 1 250 30", c, mem_en, mem_we, mem_addr, mem_wdata); end
        end
        @(negedge clk);
        n_checks++; if (d_ack !== 1'b1 || d_rdata !== 16'd0) begin n_fail++; $display("FAIL write_ack got ack=%b d_rdata=%0d exp 1 0", d_ack, d_rdata); end
        @(posedge clk); #1;
        d_req = 1'b0;
        @(negedge clk);
        n_checks++; if (mem_we !== 1'b0 || mem_wdata !== 16'd30) begin n_fail++; $display("FAIL write_idle got we=%b w=%0d exp 0 30", mem_we, mem_wdata); end
        // Read it back.
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 8'd250; d_wdata = 16'hFFFF;
        @(negedge clk);
        for (int c = 1; c <= LAT; c++) begin
            @(negedge clk);
            n_checks++; if (mem_en !== 1'b1 || mem_we !== 1'b0) begin n_fail++; $display("FAIL read_access c%0d got en=%b we=%b exp 1 0", c, mem_en, mem_we); end
        end
        @(negedge clk);
        n_checks++; if (d_ack !== 1'b1 || d_rdata !== 16'd30 || if_rdata !== 16'd5) begin n_fail++; $display("FAIL read_ack got ack=%b d=%0d if=%0d exp 1 30 5", d_ack, d_rdata, if_rdata); end
        @(posedge clk); #1;
        d_req = 1'b0;
    endtask

    task automatic test_starve();
        int  got;
        bit  ord_fetch [8];
        got = 0;
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 8'd3; d_req = 1'b1; d_we = 1'b0; d_addr = 8'd4;
        for (int c = 0; c < 80 && got < 8; c++) begin
            @(negedge clk);
            n_checks++; if (if_ack === 1'b1 && d_ack === 1'b1) begin n_fail++; $display("FAIL starve_both_acks got 1 1 exp at most one"); end
            if (if_ack === 1'b1 || d_ack === 1'b1) begin
                ord_fetch[got] = (if_ack === 1'b1);
                got++;
            end
            if (got < 8) begin
                @(posedge clk); #1;
            end
        end
        n_checks++; if (got != 8) begin n_fail++; $display("FAIL starve_timeout got %0d acks exp 8", got); end
        for (int i = 0; i < got; i++) begin
            n_checks++; if (ord_fetch[i] !== ((i % 4) == 3)) begin n_fail++; $display("FAIL starve_order idx%0d got fetch=%b exp %b", i, ord_fetch[i], ((i % 4) == 3)); end
        end
        n_checks++; if (if_rdata !== 16'd3 || d_rdata !== 16'd4) begin n_fail++; $display("FAIL starve_data got if=%0d d=%0d exp 3 4", if_rdata, d_rdata); end
        @(posedge clk); #1;
        if_req = 1'b0; d_req = 1'b0;
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 8'd7;
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (mem_en !== 1'b1 || mem_addr !== 8'd7) begin n_fail++; $display("FAIL rmid_access got en=%b a=%0d exp 1 7", mem_en, mem_addr); end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (mem_en !== 1'b0 || mem_we !== 1'b0 || d_ack !== 1'b0 || if_ack !== 1'b0) begin n_fail++; $display("FAIL rmid_after got en=%b we=%b da=%b ia=%b exp 0", mem_en, mem_we, d_ack, if_ack); end
        n_checks++; if (d_rdata !== 16'd0 || if_rdata !== 16'd0 || mem_addr !== 8'd0) begin n_fail++; $display("FAIL rmid_clear got d=%0d if=%0d a=%0d exp 0 0 0", d_rdata, if_rdata, mem_addr); end
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL rmid_stall got %b exp 1", stall); end
        // The still-high request is re-granted from IDLE and completes normally.
        for (int c = 1; c <= LAT + 1; c++) begin
            @(negedge clk);
            n_checks++; if (d_ack !== (c == LAT + 1)) begin n_fail++; $display("FAIL rmid_regrant c%0d got ack=%b exp %b", c, d_ack, (c == LAT + 1)); end
        end
        n_checks++; if (d_rdata !== 16'd7) begin n_fail++; $display("FAIL rmid_data got %0d exp 7", d_rdata); end
        @(posedge clk); #1;
        d_req = 1'b0;
    endtask

    task automatic test_back_to_back();
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 8'd10;
        for (int c = 0; c < 4 * (LAT + 2); c++) begin
            @(negedge clk);
            n_checks++; if (d_ack !== ((c % (LAT + 2)) == LAT + 1)) begin n_fail++; $display("FAIL b2b_ack c%0d got %b exp %b", c, d_ack, ((c % (LAT + 2)) == LAT + 1)); end
            n_checks++; if (stall !== ((c % (LAT + 2)) != LAT + 1)) begin n_fail++; $display("FAIL b2b_stall c%0d got %b exp %b", c, stall, ((c % (LAT + 2)) != LAT + 1)); end
            if ((c % (LAT + 2)) == LAT + 1) begin
                n_checks++; if (d_rdata !== 16'(10 + c / (LAT + 2))) begin n_fail++; $display("FAIL b2b_data c%0d got %0d exp %0d", c, d_rdata, 10 + c / (LAT + 2)); end
            end
            @(posedge clk); #1;
            if ((c % (LAT + 2)) == LAT + 1) d_addr = 8'(11 + c / (LAT + 2));
        end
        d_req = 1'b0;
    endtask

    // Randomized traffic against a timeline model: a grant decided in idle
    // cycle g yields access cycles g+1..g+LAT, the ack in g+LAT+1 and the next
    // decision in g+LAT+2.
    task automatic test_random(input int n);
        int          m_grant, m_ack, m_free, m_starve, k;
        bit          m_own_d, m_we, in_acc, is_ack, take_fetch, if_hold, d_hold;
        logic [7:0]  m_addr, e_mem_addr;
        logic [15:0] m_wdata, e_mem_wdata, e_if_rdata, e_d_rdata;
        logic        e_if_ack, e_d_ack, e_we, e_stall;
        @(posedge clk); #1;
        rst = 1'b1; if_req = 1'b0; d_req = 1'b0;
        for (int i = 0; i < 256; i++) begin mem[i] = 16'(i); ref_mem[i] = 16'(i); end
        @(posedge clk); #1;
        rst = 1'b0;
        m_grant = -100; m_ack = -100; m_free = 0; m_starve = 0;
        m_own_d = 1'b0; m_we = 1'b0; m_addr = 8'd0; m_wdata = 16'd0;
        e_mem_addr = 8'd0; e_mem_wdata = 16'd0; e_if_rdata = 16'd0; e_d_rdata = 16'd0;
        if_hold = 1'b0; d_hold = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (!if_hold) begin
                if_req  = ($urandom_range(0, 3) != 0);
                if_addr = 8'($urandom_range(0, 15));
                if_hold = if_req;
            end
            if (!d_hold) begin
                d_req   = ($urandom_range(0, 2) != 0);
                d_we    = $urandom_range(0, 1) == 1;
                d_addr  = 8'($urandom_range(0, 15));
                d_wdata = 16'($urandom);
                d_hold  = d_req;
            end
            @(negedge clk);
            k      = cyc;
            in_acc = (k > m_grant) && (k <= m_grant + LAT);
            is_ack = (k == m_ack);
            if (is_ack) begin
                if (!m_own_d) e_if_rdata = ref_mem[m_addr];
                else if (m_we) ref_mem[m_addr] = m_wdata;
                else e_d_rdata = ref_mem[m_addr];
            end
            e_if_ack = is_ack && !m_own_d;
            e_d_ack  = is_ack && m_own_d;
            e_we     = in_acc && m_own_d && m_we;
            e_stall  = (if_req && !e_if_ack) || (d_req && !e_d_ack);
            n_checks++; if (mem_en !== in_acc || mem_we !== e_we) begin n_fail++; $display("FAIL rnd_strobe cyc%0d got en=%b we=%b exp %b %b", k, mem_en, mem_we, in_acc, e_we); end
            n_checks++; if (mem_addr !== e_mem_addr || mem_wdata !== e_mem_wdata) begin n_fail++; $display("FAIL rnd_memreg cyc%0d got a=%h w=%h exp %h %h", k, mem_addr, mem_wdata, e_mem_addr, e_mem_wdata); end
            n_checks++; if (if_ack !== e_if_ack || d_ack !== e_d_ack) begin n_fail++; $display("FAIL rnd_ack cyc%0d got if=%b d=%b exp %b %b", k, if_ack, d_ack, e_if_ack, e_d_ack); end
            n_checks++; if (if_rdata !== e_if_rdata || d_rdata !== e_d_rdata) begin n_fail++; $display("FAIL rnd_rdata cyc%0d got if=%h d=%h exp %h %h", k, if_rdata, d_rdata, e_if_rdata, e_d_rdata); end
            n_checks++; if (stall !== e_stall) begin n_fail++; $display("FAIL rnd_stall cyc%0d got %b exp %b", k, stall, e_stall); end
            if (e_if_ack) if_hold = 1'b0;
            if (e_d_ack)  d_hold  = 1'b0;
            if (k >= m_free) begin
                if (if_req || d_req) begin
                    take_fetch  = if_req && (!d_req || m_starve == STARVE);
                    m_own_d     = !take_fetch;
                    m_we        = take_fetch ? 1'b0 : d_we;
                    m_addr      = take_fetch ? if_addr : d_addr;
                    m_wdata     = d_wdata;
                    e_mem_addr  = m_addr;
                    e_mem_wdata = d_wdata;
                    m_grant     = k;
                    m_ack       = k + LAT + 1;
                    m_free      = k + LAT + 2;
                    if (take_fetch || !if_req) m_starve = 0;
                    else if (m_starve < 15) m_starve++;
                end else begin
                    m_starve = 0;
                end
            end
            @(posedge clk); #1;
        end
        if_req = 1'b0; d_req = 1'b0;
        repeat (LAT + 3) @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fetch();
        test_write_read();
        test_starve();
        test_reset_mid();
        test_back_to_back();
        test_random(600);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
